// File: rtl/sequenciador_estados.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXEC/(MEM)/WB/NEXT, latches
// decode fields for the control generator, and resolves beq/bne from the ALU zero flag.
module sequenciador_estados #(
  parameter int EXEC_CYCLES = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ack,
  input  logic        mem_ready,
  input  logic        zero,
  output logic [3:0]  estado,
  output logic [2:0]  tipo,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        pc_write,
  output logic        branch_taken,
  output logic        illegal,
  output logic [15:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'b0000,
    S_DECODE = 4'b0001,
    S_EXEC   = 4'b0010,
    S_MEM    = 4'b0100,
    S_NEXT   = 4'b1000,
    S_TRAP   = 4'b1110,
    S_WB     = 4'b1111
  } state_e;

  localparam int EXEC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam int MEM_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [EXEC_W-1:0] EXEC_LAST = EXEC_W'(EXEC_CYCLES - 1);
  localparam logic [MEM_W-1:0]  MEM_LAST  = MEM_W'(MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [EXEC_W-1:0]   exec_cnt_q, exec_cnt_d;
  logic [MEM_W-1:0]    mem_cnt_q, mem_cnt_d;
  logic [2:0]          tipo_q, tipo_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [6:0]          funct7_q, funct7_d;
  logic                instr_ack_q, instr_ack_d;
  logic                branch_taken_q, branch_taken_d;
  logic [15:0]         instr_count_q, instr_count_d;

  // Only opcode[6:4], funct3 and funct7 matter to the sequencer.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7], instr[3:0]};

  function automatic logic is_legal(input logic [2:0] t, input logic [2:0] f3);
    case (t)
      3'b000, 3'b001, 3'b010, 3'b011: is_legal = 1'b1;
      3'b110:                         is_legal = (f3 == 3'b000) || (f3 == 3'b001);
      default:                        is_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d        = state_q;
    exec_cnt_d     = exec_cnt_q;
    mem_cnt_d      = mem_cnt_q;
    tipo_d         = tipo_q;
    funct3_d       = funct3_q;
    funct7_d       = funct7_q;
    instr_ack_d    = 1'b0;
    branch_taken_d = 1'b0;
    instr_count_d  = instr_count_q;

    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          tipo_d      = instr[6:4];
          funct3_d    = instr[14:12];
          funct7_d    = instr[31:25];
          instr_ack_d = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        exec_cnt_d = '0;
        state_d    = is_legal(tipo_q, funct3_q) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (exec_cnt_q == EXEC_LAST) begin
          exec_cnt_d = '0;
          mem_cnt_d  = '0;
          // Loads (000) and stores (010) are the only types that touch data memory.
          state_d    = ((tipo_q == 3'b000) || (tipo_q == 3'b010)) ? S_MEM : S_WB;
        end else begin
          exec_cnt_d = exec_cnt_q + 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          mem_cnt_d = '0;
          state_d   = S_WB;
        end else if (mem_cnt_q == MEM_LAST) begin
          mem_cnt_d = '0;
          state_d   = S_TRAP;
        end else begin
          mem_cnt_d = mem_cnt_q + 1'b1;
        end
      end
      S_WB: begin
        branch_taken_d = (tipo_q == 3'b110) &&
                         (((funct3_q == 3'b000) &&  zero) ||
                          ((funct3_q == 3'b001) && !zero));
        state_d        = S_NEXT;
      end
      S_NEXT: begin
        instr_count_d = instr_count_q + 16'd1;
        state_d       = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_FETCH;
      exec_cnt_q     <= '0;
      mem_cnt_q      <= '0;
      tipo_q         <= '0;
      funct3_q       <= '0;
      funct7_q       <= '0;
      instr_ack_q    <= 1'b0;
      branch_taken_q <= 1'b0;
      instr_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      exec_cnt_q     <= exec_cnt_d;
      mem_cnt_q      <= mem_cnt_d;
      tipo_q         <= tipo_d;
      funct3_q       <= funct3_d;
      funct7_q       <= funct7_d;
      instr_ack_q    <= instr_ack_d;
      branch_taken_q <= branch_taken_d;
      instr_count_q  <= instr_count_d;
    end
  end

  // pc_write and illegal are decoded straight from the state so they pulse exactly once.
  assign estado       = state_q;
  assign pc_write     = (state_q == S_NEXT);
  assign illegal      = (state_q == S_TRAP);
  assign instr_ack    = instr_ack_q;
  assign branch_taken = branch_taken_q;
  assign tipo         = tipo_q;
  assign funct3       = funct3_q;
  assign funct7       = funct7_q;
  assign instr_count  = instr_count_q;

endmodule
